// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: signal bundle between the fetch stage and its environment.
//   master modport : fetch unit side (drives MEM_REQ/MEM_ADDR and INSTR*)
//   slave modport  : memory / instruction-register / control side
// Signals:
//   FETCH_EN                   permit starting new fetches
//   MEM_REQ, MEM_ADDR          read request and address (address stable while MEM_REQ)
//   MEM_RDATA, MEM_ACK         read data, valid in the single-cycle MEM_ACK pulse
//   INSTR, INSTR_PC            fetched word and its address
//   INSTR_VALID, INSTR_READY   valid/ready handshake to the instruction register
//   JUMP, JUMP_ADDR            single-cycle redirect request and target
interface instr_fetch_unit_if #(
    parameter int unsigned WORD_SIZE  = 19,
    parameter int unsigned ADDR_WIDTH = 12
) ();

    logic                  FETCH_EN;
    logic                  MEM_REQ;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [WORD_SIZE-1:0]  MEM_RDATA;
    logic                  MEM_ACK;
    logic [WORD_SIZE-1:0]  INSTR;
    logic [ADDR_WIDTH-1:0] INSTR_PC;
    logic                  INSTR_VALID;
    logic                  INSTR_READY;
    logic                  JUMP;
    logic [ADDR_WIDTH-1:0] JUMP_ADDR;

    modport master (
        input  FETCH_EN,
        input  MEM_RDATA,
        input  MEM_ACK,
        input  INSTR_READY,
        input  JUMP,
        input  JUMP_ADDR,
        output MEM_REQ,
        output MEM_ADDR,
        output INSTR,
        output INSTR_PC,
        output INSTR_VALID
    );

    modport slave (
        output FETCH_EN,
        output MEM_RDATA,
        output MEM_ACK,
        output INSTR_READY,
        output JUMP,
        output JUMP_ADDR,
        input  MEM_REQ,
        input  MEM_ADDR,
        input  INSTR,
        input  INSTR_PC,
        input  INSTR_VALID
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the 19-bit CPU.
// Holds the program counter, issues one outstanding read at a time to instruction memory
// (req/ack), and hands each returned word to the instruction register (valid/ready).
// A jump redirects the PC; a fetch already in flight is completed and its data dropped.
// Ports:
//   CLK    clock, all state updates on posedge
//   RST_N  asynchronous active-low reset
//   bus    instr_fetch_unit_if.master (memory, instruction register and jump signals)
// All outputs are registered.
module instr_fetch_unit #(
    parameter int unsigned           WORD_SIZE  = 19,
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                CLK,
    input logic                RST_N,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StFull,
        StDiscard
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] PcOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]  instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;

    // Address the next request should use: a jump this cycle overrides the held PC.
    logic [ADDR_WIDTH-1:0] redirect_pc;
    // Set when the current state is finished and the next step depends on FETCH_EN.
    logic                  launch;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        launch        = 1'b0;
        redirect_pc   = bus.JUMP ? bus.JUMP_ADDR : pc_q;

        if (bus.JUMP) begin
            pc_d = bus.JUMP_ADDR;
        end

        unique case (state_q)
            StIdle: begin
                launch = bus.FETCH_EN;
            end
            StFetch: begin
                if (bus.JUMP) begin
                    // With an ack this cycle the returned word is simply not captured.
                    if (bus.MEM_ACK) begin
                        launch = 1'b1;
                    end else begin
                        state_d = StDiscard;
                    end
                end else if (bus.MEM_ACK) begin
                    instr_d       = bus.MEM_RDATA;
                    instr_pc_d    = mem_addr_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + PcOne;
                    mem_req_d     = 1'b0;
                    state_d       = StFull;
                end
            end
            StFull: begin
                // A jump ends the held instruction whether or not it is consumed this cycle.
                if (bus.JUMP || bus.INSTR_READY) begin
                    instr_valid_d = 1'b0;
                    launch        = 1'b1;
                end
            end
            StDiscard: begin
                // Old request stays on the bus untouched until memory completes it.
                launch = bus.MEM_ACK;
            end
        endcase

        if (launch) begin
            mem_addr_d = redirect_pc;
            mem_req_d  = bus.FETCH_EN;
            state_d    = bus.FETCH_EN ? StFetch : StIdle;
        end
    end

    assign bus.MEM_REQ     = mem_req_q;
    assign bus.MEM_ADDR    = mem_addr_q;
    assign bus.INSTR       = instr_q;
    assign bus.INSTR_PC    = instr_pc_q;
    assign bus.INSTR_VALID = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit.
// Part 1 applies a cycle-by-cycle vector table with a hand-driven memory.
// Part 2 runs an automatic memory model with scoreboard queues of expected request
// addresses and expected instruction transfers.
module tb_instr_fetch_unit;

    localparam int unsigned WS = 19;
    localparam int unsigned AW = 12;

    logic CLK;
    logic RST_N;

    instr_fetch_unit_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

    instr_fetch_unit #(
        .WORD_SIZE (WS),
        .ADDR_WIDTH(AW),
        .RESET_PC  (12'h000)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WS-1:0] word_of(input logic [AW-1:0] a);
        return {a[6:0] ^ 7'h35, a};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic          fen;
        logic          ack;
        logic [WS-1:0] rdata;
        logic          rdy;
        logic          jmp;
        logic [AW-1:0] jaddr;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        logic          exp_valid;
        logic [AW-1:0] exp_ipc;
        logic [WS-1:0] exp_instr;
    } vec_t;

    function automatic vec_t mk(input logic fen, input logic ack, input logic [WS-1:0] rd,
                                input logic rdy, input logic jmp, input logic [AW-1:0] ja,
                                input logic er, input logic [AW-1:0] ea, input logic ev,
                                input logic [AW-1:0] eipc, input logic [WS-1:0] ei);
        vec_t v;
        v.fen = fen; v.ack = ack; v.rdata = rd; v.rdy = rdy; v.jmp = jmp; v.jaddr = ja;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_ipc = eipc; v.exp_instr = ei;
        return v;
    endfunction

    localparam int NV = 26;
    vec_t vecs [NV];

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [AW-1:0] pc;
        logic [WS-1:0] word;
    } xfer_t;

    xfer_t         xq[$];
    logic [AW-1:0] rq[$];
    xfer_t         mon_e;
    logic [AW-1:0] mon_a;
    bit            sb_on = 0;
    int            xfer_cnt = 0;
    int            exp_gap = 0;
    int            last_xfer = -1;
    int            cyc = 0;
    bit            seen_bad = 0;
    logic          req_p = 0, ack_p = 0, rst_p = 0;
    logic [AW-1:0] addr_p = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge CLK);
            if (sb_on) begin
                if (bus.INSTR_VALID && bus.INSTR_READY) begin
                    if (xq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL xfer_unexpected: got pc %h instr %h, expected none",
                                 bus.INSTR_PC, bus.INSTR);
                    end else begin
                        mon_e = xq.pop_front();
                        chk("xfer_pc", 32'(bus.INSTR_PC), 32'(mon_e.pc));
                        chk("xfer_instr", 32'(bus.INSTR), 32'(mon_e.word));
                    end
                    if (exp_gap != 0 && last_xfer >= 0)
                        chk("xfer_gap", 32'(cyc - last_xfer), 32'(exp_gap));
                    last_xfer = cyc;
                    xfer_cnt++;
                end
                if (bus.INSTR_VALID && bus.INSTR == 19'h7ABCD) seen_bad = 1;
                if (bus.MEM_REQ && (!req_p || ack_p)) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_unexpected: got addr %h, expected none", bus.MEM_ADDR);
                    end else begin
                        mon_a = rq.pop_front();
                        chk("req_addr", 32'(bus.MEM_ADDR), 32'(mon_a));
                    end
                end
                if (req_p && !ack_p && rst_p && RST_N) begin
                    chk("req_held", 32'(bus.MEM_REQ), 32'd1);
                    chk("addr_held", 32'(bus.MEM_ADDR), 32'(addr_p));
                end
            end
            req_p  = bus.MEM_REQ;
            ack_p  = bus.MEM_ACK;
            addr_p = bus.MEM_ADDR;
            rst_p  = RST_N;
        end
    end

    // ---------------- memory model ----------------
    bit            mem_on = 0;
    bit            pend = 0;
    int            cnt = 0;
    logic [AW-1:0] paddr;
    bit            special_on = 0;
    logic [AW-1:0] special_addr;
    int            special_lat;
    logic [WS-1:0] special_data;

    // A latched request is answered even if the DUT is reset meanwhile (stray ack).
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (mem_on) begin
                bus.MEM_ACK = 1'b0;
                if (pend) begin
                    cnt++;
                end else if (bus.MEM_REQ) begin
                    pend  = 1;
                    cnt   = 0;
                    paddr = bus.MEM_ADDR;
                end
                if (pend && cnt >= ((special_on && paddr == special_addr) ? special_lat : 1)) begin
                    bus.MEM_ACK   = 1'b1;
                    bus.MEM_RDATA = (special_on && paddr == special_addr) ? special_data
                                                                          : word_of(paddr);
                    pend = 0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        sb_on = 0;
        mem_on = 0;
        bus.FETCH_EN = 0; bus.MEM_ACK = 0; bus.MEM_RDATA = '0;
        bus.INSTR_READY = 0; bus.JUMP = 0; bus.JUMP_ADDR = '0;
        RST_N = 0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1;
        rq.delete();
        xq.delete();
        xfer_cnt = 0; last_xfer = -1; exp_gap = 0; special_on = 0; pend = 0; seen_bad = 0;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_xfers(input int n);
        int t = 0;
        while (xfer_cnt < n && t < 200) begin
            @(posedge CLK);
            t++;
        end
        if (xfer_cnt < n) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got %0d transfers, expected %0d", xfer_cnt, n);
        end
        #1;
    endtask

    task automatic end_test(input string name);
        repeat (6) @(posedge CLK);
        #1;
        chk({name, "_req_q_empty"}, 32'(rq.size()), 32'd0);
        chk({name, "_xfer_q_empty"}, 32'(xq.size()), 32'd0);
    endtask

    task automatic push_run(input logic [AW-1:0] first, input int n);
        xfer_t x;
        for (int i = 0; i < n; i++) begin
            rq.push_back(first + AW'(i));
            x.pc = first + AW'(i);
            x.word = word_of(x.pc);
            xq.push_back(x);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_req"}, 32'(bus.MEM_REQ), 32'd0);
        chk({name, "_addr"}, 32'(bus.MEM_ADDR), 32'h000);
        chk({name, "_instr"}, 32'(bus.INSTR), 32'd0);
        chk({name, "_ipc"}, 32'(bus.INSTR_PC), 32'd0);
        chk({name, "_valid"}, 32'(bus.INSTR_VALID), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;
        xfer_t x;

        //              fen ack rdata     rdy jmp jaddr    req addr     vld ipc      instr
        vecs[0]  = mk(0, 0, 19'h0,     0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 19'h0);
        vecs[1]  = mk(1, 0, 19'h0,     0, 0, 12'h000, 1, 12'h000, 0, 12'h000, 19'h0);
        vecs[2]  = mk(1, 0, 19'h0,     0, 0, 12'h000, 1, 12'h000, 0, 12'h000, 19'h0);
        vecs[3]  = mk(1, 1, 19'h12345, 0, 0, 12'h000, 0, 12'h000, 1, 12'h000, 19'h12345);
        vecs[4]  = mk(1, 1, 19'h6AAAA, 0, 0, 12'h000, 0, 12'h000, 1, 12'h000, 19'h12345);
        vecs[5]  = mk(1, 0, 19'h0,     0, 1, 12'h3A0, 1, 12'h3A0, 0, 12'h000, 19'h0);
        vecs[6]  = mk(1, 0, 19'h0,     0, 1, 12'h100, 1, 12'h3A0, 0, 12'h000, 19'h0);
        vecs[7]  = mk(1, 0, 19'h0,     0, 1, 12'h200, 1, 12'h3A0, 0, 12'h000, 19'h0);
        vecs[8]  = mk(1, 1, 19'h7ABCD, 0, 0, 12'h000, 1, 12'h200, 0, 12'h000, 19'h0);
        vecs[9]  = mk(1, 1, 19'h55555, 0, 1, 12'hFFF, 1, 12'hFFF, 0, 12'h000, 19'h0);
        vecs[10] = mk(0, 1, 19'h0AAAA, 0, 0, 12'h000, 0, 12'h000, 1, 12'hFFF, 19'h0AAAA);
        vecs[11] = mk(0, 0, 19'h0,     1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 19'h0);
        vecs[12] = mk(1, 0, 19'h0,     0, 0, 12'h000, 1, 12'h000, 0, 12'h000, 19'h0);
        vecs[13] = mk(1, 1, 19'h13579, 0, 0, 12'h000, 0, 12'h000, 1, 12'h000, 19'h13579);
        vecs[14] = mk(1, 0, 19'h0,     1, 1, 12'hABC, 1, 12'hABC, 0, 12'h000, 19'h0);
        vecs[15] = mk(0, 0, 19'h0,     0, 0, 12'h000, 1, 12'hABC, 0, 12'h000, 19'h0);
        vecs[16] = mk(0, 1, 19'h00042, 0, 0, 12'h000, 0, 12'h000, 1, 12'hABC, 19'h00042);
        vecs[17] = mk(1, 0, 19'h0,     1, 0, 12'h000, 1, 12'hABD, 0, 12'h000, 19'h0);
        vecs[18] = mk(1, 0, 19'h0,     0, 1, 12'h050, 1, 12'hABD, 0, 12'h000, 19'h0);
        vecs[19] = mk(0, 1, 19'h0,     0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 19'h0);
        vecs[20] = mk(1, 0, 19'h0,     0, 0, 12'h000, 1, 12'h050, 0, 12'h000, 19'h0);
        vecs[21] = mk(0, 1, 19'h1ABCD, 0, 0, 12'h000, 0, 12'h000, 1, 12'h050, 19'h1ABCD);
        vecs[22] = mk(0, 0, 19'h0,     1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 19'h0);
        vecs[23] = mk(1, 0, 19'h0,     0, 1, 12'h777, 1, 12'h777, 0, 12'h000, 19'h0);
        vecs[24] = mk(0, 1, 19'h7FFFF, 0, 0, 12'h000, 0, 12'h000, 1, 12'h777, 19'h7FFFF);
        vecs[25] = mk(0, 0, 19'h0,     1, 0, 12'h000, 0, 12'h000, 0, 12'h000, 19'h0);

        RST_N = 0;
        do_reset();
        @(negedge CLK);
        chk_reset_vals("reset");
        @(posedge CLK);
        #1;

        // Part 1: vector table, memory driven by hand.
        for (int i = 0; i < NV; i++) begin
            bus.FETCH_EN    = vecs[i].fen;
            bus.MEM_ACK     = vecs[i].ack;
            bus.MEM_RDATA   = vecs[i].rdata;
            bus.INSTR_READY = vecs[i].rdy;
            bus.JUMP        = vecs[i].jmp;
            bus.JUMP_ADDR   = vecs[i].jaddr;
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_req", i), 32'(bus.MEM_REQ), 32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_valid", i), 32'(bus.INSTR_VALID), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_req)
                chk($sformatf("vec%0d_addr", i), 32'(bus.MEM_ADDR), 32'(vecs[i].exp_addr));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_ipc", i), 32'(bus.INSTR_PC), 32'(vecs[i].exp_ipc));
                chk($sformatf("vec%0d_instr", i), 32'(bus.INSTR), 32'(vecs[i].exp_instr));
            end
        end

        // Test A: streaming from reset, READY high, one instruction every 3 cycles.
        do_reset();
        push_run(12'h000, 4);
        exp_gap = 3;
        mem_on = 1; sb_on = 1;
        bus.INSTR_READY = 1;
        bus.FETCH_EN = 1;
        wait_xfers(3);
        bus.FETCH_EN = 0;
        wait_xfers(4);
        end_test("stream");

        // Test B: READY held low five cycles while VALID is high.
        do_reset();
        push_run(12'h000, 2);
        mem_on = 1; sb_on = 1;
        bus.FETCH_EN = 1;
        t = 0;
        while (!bus.INSTR_VALID && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("stall_valid_seen", 32'(bus.INSTR_VALID), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_instr", 32'(bus.INSTR), 32'(word_of(12'h000)));
            chk("stall_ipc", 32'(bus.INSTR_PC), 32'h000);
            chk("stall_req", 32'(bus.MEM_REQ), 32'd0);
            chk("stall_valid", 32'(bus.INSTR_VALID), 32'd1);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1 bus.INSTR_READY = 1;
        wait_xfers(1);
        bus.FETCH_EN = 0;
        wait_xfers(2);
        end_test("stall");

        // Test C: jump to 12'h3A0 while fetching address 5 with a slow ack.
        do_reset();
        special_on = 1; special_addr = 12'h005; special_lat = 3; special_data = 19'h7ABCD;
        push_run(12'h000, 5);
        rq.push_back(12'h005);
        push_run(12'h3A0, 2);
        mem_on = 1; sb_on = 1;
        bus.INSTR_READY = 1;
        bus.FETCH_EN = 1;
        t = 0;
        while (!(bus.MEM_REQ && bus.MEM_ADDR == 12'h005) && t < 100) begin
            @(negedge CLK);
            t++;
        end
        chk("jump_req5_seen", 32'(bus.MEM_ADDR), 32'h005);
        @(posedge CLK);
        #1 bus.JUMP = 1; bus.JUMP_ADDR = 12'h3A0;
        @(posedge CLK);
        #1 bus.JUMP = 0;
        wait_xfers(6);
        bus.FETCH_EN = 0;
        wait_xfers(7);
        end_test("jump");
        chk("jump_dropped_hidden", 32'(seen_bad), 32'd0);

        // Test D: PC wrap from 12'hFFF to 12'h000 after a jump issued from IDLE.
        do_reset();
        push_run(12'hFFE, 2);
        x.pc = 12'h000; x.word = word_of(12'h000);
        rq.push_back(12'h000);
        xq.push_back(x);
        mem_on = 1; sb_on = 1;
        bus.INSTR_READY = 1;
        bus.FETCH_EN = 1; bus.JUMP = 1; bus.JUMP_ADDR = 12'hFFE;
        @(posedge CLK);
        #1 bus.JUMP = 0;
        wait_xfers(2);
        bus.FETCH_EN = 0;
        wait_xfers(3);
        end_test("wrap");

        // Test E: reset pulse mid-request, stray ack lands in IDLE, then refetch.
        do_reset();
        special_on = 1; special_addr = 12'h000; special_lat = 4; special_data = word_of(12'h000);
        rq.push_back(12'h000);
        push_run(12'h000, 1);
        mem_on = 1; sb_on = 1;
        bus.INSTR_READY = 1;
        bus.FETCH_EN = 1;
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 0; bus.FETCH_EN = 0;
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("stray_ack_seen", 32'(pend), 32'd0);
        chk_reset_vals("midreset");
        @(posedge CLK);
        #1 bus.FETCH_EN = 1;
        @(posedge CLK);
        #1 bus.FETCH_EN = 0;
        wait_xfers(1);
        end_test("midreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
